conv1_calc: RTL and testbench

Pipelined 7x7 convolution engine that consumes the sliding windows produced by the `conv1_buf` line buffer and returns one filtered, ReLU-activated, saturated pixel per accepted window. It drives the buffer's `calc_ready` input as its backpressure signal and presents results to the downstream pooling stage over a valid/ready handshake. Weights and bias are written through a simple register-write port before or between frames.

---
 rtl/conv1_pkg.sv | 40 ++++
 rtl/conv1_row_mac.sv | 57 +++++
 rtl/conv1_calc.sv | 127 ++++++++++++
 tb/tb_conv1_calc.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1_pkg.sv
// rtl/conv1_pkg.sv - shared constants, types and output activation for the conv1 engine
//
// Purpose: tap/weight/row-sum types shared by conv1_calc and conv1_row_mac,
// plus the ReLU + shift + saturate stage applied to each accumulated window.
// Ports: none (package).
package conv1_pkg;

  localparam int NUM_TAPS  = 49;
  localparam int BIAS_ADDR = 49;
  localparam int TAP_BITS  = 9;
  localparam int WGT_BITS  = 8;
  localparam int PROD_BITS = TAP_BITS + WGT_BITS;
  // Seven 17-bit products need three guard bits.
  localparam int ROW_BITS  = PROD_BITS + 3;
  localparam int ACC_W     = 24;
  localparam int PIX_BITS  = 8;

  typedef logic signed [TAP_BITS-1:0]  tap_t;
  typedef logic signed [WGT_BITS-1:0]  weight_t;
  typedef logic signed [ROW_BITS-1:0]  row_sum_t;
  typedef logic signed [ACC_W-1:0]     acc_t;

  // Negative sums clamp to 0; non-negative sums are shifted then clamped to
  // the largest unsigned pixel value.
  function automatic logic [PIX_BITS-1:0] relu_shift_sat(input acc_t acc,
                                                         input int unsigned shift);
    logic [PIX_BITS-1:0] r;
    acc_t                s;
    s = acc >>> shift;
    if (acc[ACC_W-1]) begin
      r = '0;
    end else if (s > acc_t'((1 << PIX_BITS) - 1)) begin
      r = '1;
    end else begin
      r = s[PIX_BITS-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/conv1_row_mac.sv
// rtl/conv1_row_mac.sv - one kernel row: registered products (S1) then registered row sum (S2)
//
// Purpose: multiplies TAPS window taps by their weights, registers the
// products, sums them and registers the row sum. Both stages advance only
// while en is high, so a stalled pipeline keeps its contents.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   en               pipeline advance
//   in_valid         window valid entering S1
//   taps, weights    TAPS signed taps and weights for this row
//   out_valid        valid leaving S2
//   row_sum          registered signed sum of the row products
module conv1_row_mac
  import conv1_pkg::*;
#(
  parameter int TAPS = 7
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  logic     in_valid,
  input  tap_t     taps    [TAPS],
  input  weight_t  weights [TAPS],
  output logic     out_valid,
  output row_sum_t row_sum
);

  logic signed [PROD_BITS-1:0] prod_q [TAPS];
  logic                        s1_valid;
  row_sum_t                    sum_c;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < TAPS; i++) begin
      sum_c = sum_c + ROW_BITS'(prod_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      row_sum   <= '0;
      for (int i = 0; i < TAPS; i++) begin
        prod_q[i] <= '0;
      end
    end else if (en) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      row_sum   <= sum_c;
      for (int i = 0; i < TAPS; i++) begin
        prod_q[i] <= PROD_BITS'(taps[i]) * PROD_BITS'(weights[i]);
      end
    end
  end

endmodule

// File: rtl/conv1_calc.sv
// rtl/conv1_calc.sv - pipelined 7x7 convolution with ReLU, shift and saturation
//
// Purpose: accepts one window per cycle from the line buffer and returns one
// filtered pixel per window, three register stages later, over valid/ready.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   win_valid, win_data      incoming window (taps row-major, r*F+c)
//   calc_ready               window accepted this cycle when win_valid is high
//   w_we, w_addr, w_data     weight write port (0..48 taps, 49 bias)
//   res_valid, res_ready     result handshake
//   res_data                 unsigned result pixel
//   res_last                 final result of a frame
module conv1_calc
  import conv1_pkg::*;
#(
  parameter int WIDTH       = 28,
  parameter int HEIGHT      = 28,
  parameter int DATA_BITS   = 8,
  parameter int FILTER_SIZE = 7,
  parameter int WEIGHT_BITS = 8,
  parameter int ACC_BITS    = 24,
  parameter int SHIFT       = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   win_valid,
  input  logic signed [DATA_BITS:0] win_data [FILTER_SIZE*FILTER_SIZE],
  output logic                   calc_ready,
  input  logic                   w_we,
  input  logic [5:0]             w_addr,
  input  logic signed [WEIGHT_BITS-1:0] w_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_BITS-1:0]   res_data,
  output logic                   res_last
);

  localparam int LAST_IDX = (HEIGHT - FILTER_SIZE + 1) * (WIDTH - FILTER_SIZE + 1) - 1;
  localparam int CNT_W    = $clog2(LAST_IDX + 1);

  logic                          en;
  logic signed [WEIGHT_BITS-1:0] wgt [NUM_TAPS];
  logic signed [WEIGHT_BITS-1:0] bias, bias_s1, bias_s2;
  logic [FILTER_SIZE-1:0]        row_valid;
  row_sum_t                      row_sum [FILTER_SIZE];
  logic signed [ACC_BITS-1:0]    acc;
  logic [CNT_W-1:0]              res_cnt;

  assign en         = ~res_valid | res_ready;
  assign calc_ready = en;
  assign res_last   = res_valid & (res_cnt == CNT_W'(LAST_IDX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        wgt[k] <= '0;
      end
    end else if (w_we) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        if (w_addr == 6'(k)) wgt[k] <= w_data;
      end
      if (w_addr == 6'(BIAS_ADDR)) bias <= w_data;
    end
  end

  // Products use the weights sampled at acceptance; the bias travels with the
  // window so a bias write mid-flight cannot tear a result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_s1 <= '0;
      bias_s2 <= '0;
    end else if (en) begin
      bias_s1 <= bias;
      bias_s2 <= bias_s1;
    end
  end

  for (genvar r = 0; r < FILTER_SIZE; r++) begin : g_row
    tap_t    rt [FILTER_SIZE];
    weight_t rw [FILTER_SIZE];

    always_comb begin
      for (int c = 0; c < FILTER_SIZE; c++) begin
        rt[c] = win_data[r*FILTER_SIZE + c];
        rw[c] = wgt[r*FILTER_SIZE + c];
      end
    end

    conv1_row_mac #(.TAPS(FILTER_SIZE)) u_row (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (win_valid),
      .taps      (rt),
      .weights   (rw),
      .out_valid (row_valid[r]),
      .row_sum   (row_sum[r])
    );
  end

  always_comb begin
    acc = ACC_BITS'(bias_s2);
    for (int r = 0; r < FILTER_SIZE; r++) begin
      acc = acc + ACC_BITS'(row_sum[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (en) begin
      res_valid <= &row_valid;
      res_data  <= relu_shift_sat(acc, SHIFT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt <= '0;
    end else if (res_valid & res_ready) begin
      res_cnt <= (res_cnt == CNT_W'(LAST_IDX)) ? '0 : res_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_conv1_calc.sv
// tb/tb_conv1_calc.sv - self-checking bench for conv1_calc
module tb_conv1_calc;

  localparam int NT       = 49;
  localparam int SHIFT    = 7;
  localparam int LAST_IDX = 483;

  logic              clk = 1'b0;
  logic              rst;
  logic              win_valid;
  logic signed [8:0] win_data [NT];
  logic              calc_ready;
  logic              w_we;
  logic [5:0]        w_addr;
  logic signed [7:0] w_data;
  logic              res_valid;
  logic              res_ready;
  logic [7:0]        res_data;
  logic              res_last;

  int taps [NT];

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NT; k++) begin
      win_data[k] = 9'(taps[k]);
    end
  end

  conv1_calc #(
    .WIDTH(28), .HEIGHT(28), .DATA_BITS(8), .FILTER_SIZE(7),
    .WEIGHT_BITS(8), .ACC_BITS(24), .SHIFT(SHIFT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .win_valid  (win_valid),
    .win_data   (win_data),
    .calc_ready (calc_ready),
    .w_we       (w_we),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_last   (res_last)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: weighted sum plus bias, ReLU, shift, clamp to 255.
  function automatic int model_pix(input int t [NT], input int wt [50]);
    int s;
    s = wt[49];
    for (int k = 0; k < NT; k++) s += t[k] * wt[k];
    if (s < 0) return 0;
    s = s / (1 << SHIFT);
    if (s > 255) return 255;
    return s;
  endfunction

  int mw [50];
  int exp_q [$];
  int got_data [$];
  int got_last [$];
  int got_cyc [$];
  int last_acc_cyc;
  int frame_idx;
  bit hold;
  int hold_data, hold_last;

  always @(negedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      exp_q.delete();
      frame_idx = 0;
      hold = 0;
      for (int k = 0; k < 50; k++) mw[k] = 0;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_last", res_last, 0);
      chk("rst_calc_ready", calc_ready, 1);
    end else begin
      chk("calc_ready_rule", calc_ready, int'(!res_valid || res_ready));
      if (hold) begin
        chk("stall_valid", res_valid, 1);
        chk("stall_data", res_data, hold_data);
        chk("stall_last", res_last, hold_last);
      end
      if (!res_valid) chk("last_without_valid", res_last, 0);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("res_data", res_data, exp_q.pop_front());
          chk("res_last", res_last, int'(frame_idx == LAST_IDX));
        end
        got_data.push_back(res_data);
        got_last.push_back(res_last);
        got_cyc.push_back(cyc);
        frame_idx = (frame_idx == LAST_IDX) ? 0 : frame_idx + 1;
      end
      hold      = res_valid && !res_ready;
      hold_data = res_data;
      hold_last = res_last;
      if (win_valid && calc_ready) begin
        exp_q.push_back(model_pix(taps, mw));
        last_acc_cyc = cyc;
      end
      if (w_we && w_addr < 6'd50) mw[w_addr] = int'(w_data);
    end
  end

  task automatic clear_got();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; win_valid = 1'b0; w_we = 1'b0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_w(input int a, input int v);
    @(negedge clk);
    w_we = 1'b1; w_addr = 6'(a); w_data = 8'(v);
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic set_all_w(input int v, input int b);
    for (int a = 0; a < NT; a++) begin
      @(negedge clk);
      w_we = 1'b1; w_addr = 6'(a); w_data = 8'(v);
    end
    @(negedge clk);
    w_addr = 6'd49; w_data = 8'(b);
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic feed_one(input int v);
    @(negedge clk);
    for (int k = 0; k < NT; k++) taps[k] = v;
    win_valid = 1'b1;
    @(negedge clk);
    win_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int t = 0;
    while (got_data.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    if (got_data.size() < n) chk("result_timeout", got_data.size(), n);
  endtask

  initial begin
    int nxt, nl, li;
    bit stall_seen;
    rst = 1'b1; win_valid = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0; res_ready = 1'b1;
    for (int k = 0; k < NT; k++) taps[k] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 49 * 128 = 6272, >> 7 = 49; result three cycles after acceptance
    set_all_w(1, 0);
    clear_got();
    feed_one(128);
    wait_results(1, 20);
    if (got_data.size() >= 1) begin
      chk("lit_shift_49", got_data[0], 49);
      chk("lit_latency", got_cyc[0] - last_acc_cyc, 3);
    end

    // bias path: 49 + 127 = 176, >> 7 = 1
    set_all_w(1, 127);
    clear_got();
    feed_one(1);
    wait_results(1, 20);
    if (got_data.size() >= 1) chk("lit_bias_1", got_data[0], 1);

    // ReLU: sum -49 clamps to 0
    do_reset();
    set_all_w(-1, 0);
    clear_got();
    feed_one(1);
    wait_results(1, 20);
    if (got_data.size() >= 1) chk("lit_relu_0", got_data[0], 0);

    // Saturation: 49*255*127 >> 7 far above 255
    set_all_w(127, 0);
    clear_got();
    feed_one(255);
    wait_results(1, 20);
    if (got_data.size() >= 1) chk("lit_sat_255", got_data[0], 255);

    // Backpressure: center tap 2v with w[24]=64 gives result v
    do_reset();
    write_w(24, 64);
    clear_got();
    nxt = 0;
    stall_seen = 0;
    for (int i = 0; i < 60 && got_data.size() < 10; i++) begin
      @(negedge clk);
      res_ready = !(i >= 4 && i <= 8);
      if (nxt < 10) begin
        win_valid = 1'b1;
        for (int k = 0; k < NT; k++) taps[k] = int'($urandom_range(0, 255));
        taps[24] = 2 * nxt;
      end else begin
        win_valid = 1'b0;
      end
      #2;
      if (!calc_ready) stall_seen = 1;
      if (win_valid && calc_ready) nxt++;
    end
    @(negedge clk);
    win_valid = 1'b0; res_ready = 1'b1;
    wait_results(10, 20);
    chk("bp_stall_seen", int'(stall_seen), 1);
    chk("bp_count", got_data.size(), 10);
    if (got_data.size() >= 10)
      for (int v = 0; v < 10; v++) chk("bp_order", got_data[v], v);

    // Randomized streaming with weight writes and random backpressure
    do_reset();
    for (int a = 0; a < 50; a++) write_w(a, int'($urandom_range(0, 8)) - 4);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      res_ready = ($urandom_range(0, 3) != 0);
      win_valid = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < NT; k++)
        taps[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) - 256
                                              : int'($urandom_range(0, 255));
      w_we   = ($urandom_range(0, 15) == 0);
      w_addr = 6'($urandom_range(0, 63));
      if (w_addr == 6'd49 || $urandom_range(0, 7) == 0) w_data = 8'($urandom_range(0, 255));
      else w_data = 8'(int'($urandom_range(0, 8)) - 4);
    end
    @(negedge clk);
    win_valid = 1'b0; w_we = 1'b0; res_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("random_drain", exp_q.size(), 0);

    // Frame: res_last only on result index 483, counter wraps afterwards
    do_reset();
    write_w(24, 64);
    clear_got();
    for (int i = 0; i < 489; i++) begin
      @(negedge clk);
      win_valid = 1'b1;
      for (int k = 0; k < NT; k++) taps[k] = int'($urandom_range(0, 255));
    end
    @(negedge clk);
    win_valid = 1'b0;
    wait_results(489, 20);
    nl = 0;
    li = -1;
    foreach (got_last[j]) if (got_last[j] != 0) begin
      nl++;
      if (li < 0) li = j;
    end
    chk("frame_last_count", nl, 1);
    chk("frame_last_index", li, LAST_IDX);

    // Reset with two results in flight
    clear_got();
    @(negedge clk);
    win_valid = 1'b1;
    for (int k = 0; k < NT; k++) taps[k] = 200;
    @(negedge clk);
    @(negedge clk);
    win_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_stale_results", got_data.size(), 0);
    chk("post_reset_ready", calc_ready, 1);

    // Weights cleared by reset: any window gives 0
    clear_got();
    feed_one(255);
    wait_results(1, 20);
    if (got_data.size() >= 1) chk("weights_cleared", got_data[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
